// File: rtl/voice_allocator_if.sv
`default_nettype none
// ============================================================================
// Module   : voice_allocator_if
// Brief    : Key-scanner / voice-datapath bundle for the voice allocator.
// Revision : 1.0
// ============================================================================
interface voice_allocator_if #(
    parameter int NUM_KEYS   = 16,
    parameter int NUM_VOICES = 4,
    parameter int KEY_W      = 4
);
    logic                        enable;
    logic [NUM_KEYS-1:0]         keys;
    logic [15:0]                 release_len;
    logic [NUM_VOICES-1:0]       voice_gate;
    logic [NUM_VOICES*KEY_W-1:0] voice_key;
    logic [NUM_VOICES-1:0]       voice_trig;
    logic                        steal;
    logic                        busy;

    modport master (
        output enable, keys, release_len,
        input  voice_gate, voice_key, voice_trig, steal, busy
    );

    modport slave (
        input  enable, keys, release_len,
        output voice_gate, voice_key, voice_trig, steal, busy
    );
endinterface
`default_nettype wire

// File: rtl/voice_allocator.sv
`default_nettype none
// ============================================================================
// Module   : voice_allocator
// Brief    : Maps key press/release events onto a voice pool, oldest-first steal.
// Revision : 1.0
// ============================================================================
module voice_allocator #(
    parameter int NUM_KEYS   = 16,
    parameter int NUM_VOICES = 4,
    parameter int KEY_W      = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    voice_allocator_if.slave bus
);
    localparam int VID_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    localparam logic [1:0] c_FREE      = 2'd0;
    localparam logic [1:0] c_HELD      = 2'd1;
    localparam logic [1:0] c_RELEASING = 2'd2;

    logic [NUM_KEYS-1:0]         r_keys_prev, r_press_pend, r_release_pend;
    logic [1:0]                  r_state [NUM_VOICES];
    logic [15:0]                 r_cnt   [NUM_VOICES];
    logic [VID_W-1:0]            r_rank  [NUM_VOICES];
    logic [NUM_VOICES-1:0]       r_gate, r_trig;
    logic [NUM_VOICES*KEY_W-1:0] r_key;
    logic                        r_steal, r_busy;

    logic [NUM_KEYS-1:0] w_pwork, w_rwork, w_pavail, w_ravail, w_p1h, w_r1h;
    logic [NUM_KEYS-1:0] w_press_next, w_release_next;
    logic [KEY_W-1:0]    w_press_key, w_rel_key;
    logic                w_do_rel, w_do_press;
    logic                w_hit, w_free, w_orel, w_ohld, w_tgt_steal;
    logic [VID_W-1:0]    w_hit_v, w_free_v, w_orel_v, w_ohld_v, w_tgt;
    logic [VID_W-1:0]    w_orel_rank, w_ohld_rank, w_tgt_rank;

    always_comb begin
        w_pwork  = r_press_pend | (bus.keys & ~r_keys_prev);
        w_rwork  = r_release_pend | (~bus.keys & r_keys_prev);
        // A press released before it was serviced never reaches a voice.
        w_pavail = w_pwork & ~(w_pwork & w_rwork);
        w_ravail = w_rwork & ~(w_pwork & w_rwork);
        w_p1h    = w_pavail & (~w_pavail + NUM_KEYS'(1));
        w_r1h    = w_ravail & (~w_ravail + NUM_KEYS'(1));
        w_do_rel   = |w_ravail;
        w_do_press = !w_do_rel && (|w_pavail);
        w_press_key = '0;
        w_rel_key   = '0;
        for (int k = NUM_KEYS - 1; k >= 0; k--) begin
            if (w_pavail[k]) w_press_key = KEY_W'(k);
            if (w_ravail[k]) w_rel_key   = KEY_W'(k);
        end
        w_release_next = w_ravail & ~w_r1h;
        w_press_next   = w_do_press ? (w_pavail & ~w_p1h) : w_pavail;

        w_hit = 1'b0;  w_hit_v  = '0;
        w_free = 1'b0; w_free_v = '0;
        for (int v = NUM_VOICES - 1; v >= 0; v--) begin
            if (r_state[v] == c_RELEASING && r_key[v*KEY_W +: KEY_W] == w_press_key) begin
                w_hit = 1'b1; w_hit_v = VID_W'(v);
            end
            if (r_state[v] == c_FREE) begin
                w_free = 1'b1; w_free_v = VID_W'(v);
            end
        end
        w_orel = 1'b0; w_orel_v = '0; w_orel_rank = '0;
        w_ohld = 1'b0; w_ohld_v = '0; w_ohld_rank = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (r_state[v] == c_RELEASING && (!w_orel || r_rank[v] > w_orel_rank)) begin
                w_orel = 1'b1; w_orel_v = VID_W'(v); w_orel_rank = r_rank[v];
            end
            if (r_state[v] == c_HELD && (!w_ohld || r_rank[v] > w_ohld_rank)) begin
                w_ohld = 1'b1; w_ohld_v = VID_W'(v); w_ohld_rank = r_rank[v];
            end
        end

        if (w_hit) begin
            w_tgt = w_hit_v;  w_tgt_steal = 1'b0;
        end else if (w_free) begin
            w_tgt = w_free_v; w_tgt_steal = 1'b0;
        end else if (w_orel) begin
            w_tgt = w_orel_v; w_tgt_steal = 1'b1;
        end else begin
            w_tgt = w_ohld_v; w_tgt_steal = 1'b1;
        end
        w_tgt_rank = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (VID_W'(v) == w_tgt) w_tgt_rank = r_rank[v];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_keys_prev    <= '0;
            r_press_pend   <= '0;
            r_release_pend <= '0;
            r_gate         <= '0;
            r_trig         <= '0;
            r_key          <= '0;
            r_steal        <= 1'b0;
            r_busy         <= 1'b0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                r_state[v] <= c_FREE;
                r_cnt[v]   <= '0;
                r_rank[v]  <= VID_W'(v);
            end
        end else begin
            r_keys_prev <= bus.keys;
            r_trig      <= '0;
            r_steal     <= 1'b0;
            if (!bus.enable) begin
                r_press_pend   <= '0;
                r_release_pend <= '0;
                r_busy         <= 1'b0;
                r_gate         <= '0;
                for (int v = 0; v < NUM_VOICES; v++) begin
                    r_state[v] <= c_FREE;
                    r_cnt[v]   <= '0;
                end
            end else begin
                r_press_pend   <= w_press_next;
                r_release_pend <= w_release_next;
                r_busy         <= |(w_press_next | w_release_next);
                for (int v = 0; v < NUM_VOICES; v++) begin
                    // >= so a live drop of release_len below the count still frees.
                    if (r_state[v] == c_RELEASING) begin
                        if (r_cnt[v] >= bus.release_len) begin
                            r_state[v] <= c_FREE;
                            r_cnt[v]   <= '0;
                        end else if (r_cnt[v] != 16'hFFFF) begin
                            r_cnt[v] <= r_cnt[v] + 16'd1;
                        end
                    end
                    if (w_do_rel && r_state[v] == c_HELD &&
                        r_key[v*KEY_W +: KEY_W] == w_rel_key) begin
                        r_state[v] <= c_RELEASING;
                        r_cnt[v]   <= '0;
                        r_gate[v]  <= 1'b0;
                    end
                    if (w_do_press) begin
                        if (VID_W'(v) == w_tgt) begin
                            r_state[v]               <= c_HELD;
                            r_cnt[v]                 <= '0;
                            r_gate[v]                <= 1'b1;
                            r_trig[v]                <= 1'b1;
                            r_key[v*KEY_W +: KEY_W]  <= w_press_key;
                            r_rank[v]                <= '0;
                        end else if (r_rank[v] < w_tgt_rank) begin
                            r_rank[v] <= r_rank[v] + VID_W'(1);
                        end
                    end
                end
                if (w_do_press) r_steal <= w_tgt_steal;
            end
        end
    end

    assign bus.voice_gate = r_gate;
    assign bus.voice_key  = r_key;
    assign bus.voice_trig = r_trig;
    assign bus.steal      = r_steal;
    assign bus.busy       = r_busy;
endmodule
`default_nettype wire

// File: tb/tb_voice_allocator.sv
`default_nettype none
// ============================================================================
// Module   : tb_voice_allocator
// Brief    : Directed stimulus with a queued scoreboard of expected output events.
// Revision : 1.0
// ============================================================================
module tb_voice_allocator;
    typedef struct packed {
        logic [3:0]  gate;
        logic [15:0] key;
        logic [3:0]  trig;
        logic        steal;
        logic        busy;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n;
    logic mon_en = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   n_events = 0;
    ev_t  exp_q[$];
    logic [3:0] prev_gate = 4'b0;
    logic       prev_busy = 1'b0;

    voice_allocator_if #(.NUM_KEYS(16), .NUM_VOICES(4), .KEY_W(4)) bus ();

    voice_allocator #(.NUM_KEYS(16), .NUM_VOICES(4), .KEY_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic ev_t snap();
        return {bus.voice_gate, bus.voice_key, bus.voice_trig, bus.steal, bus.busy};
    endfunction

    task automatic expect_ev(input logic [3:0] g, input logic [15:0] k,
                             input logic [3:0] t, input logic s, input logic b);
        exp_q.push_back({g, k, t, s, b});
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_now(input string name, input ev_t req);
        ev_t got;
        got = snap();
        n_checks++;
        if (got === req) n_pass++;
        else $display("FAIL %s got=%h required=%h", name, got, req);
    endtask

    // Any change in gate/busy or any trig/steal pulse is an event that must match the queue head.
    always @(negedge clk) begin : monitor
        ev_t got;
        ev_t req;
        got = snap();
        if (mon_en && (bus.voice_trig !== 4'b0 || bus.steal !== 1'b0 ||
                       bus.voice_gate !== prev_gate || bus.busy !== prev_busy)) begin
            n_checks++;
            n_events++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_event_%0d got gate=%b key=%h trig=%b steal=%b busy=%b",
                         n_events, got.gate, got.key, got.trig, got.steal, got.busy);
            end else begin
                req = exp_q.pop_front();
                if (got === req) n_pass++;
                else $display("FAIL event_%0d got gate=%b key=%h trig=%b steal=%b busy=%b required gate=%b key=%h trig=%b steal=%b busy=%b",
                              n_events, got.gate, got.key, got.trig, got.steal, got.busy,
                              req.gate, req.key, req.trig, req.steal, req.busy);
            end
        end
        prev_gate = bus.voice_gate;
        prev_busy = bus.busy;
    end

    initial begin
        rst_n           = 1'b0;
        bus.enable      = 1'b1;
        bus.keys        = 16'h0000;
        bus.release_len = 16'd4;
        repeat (2) @(posedge clk);
        #1;
        check_now("reset_state", '0);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Single note on voice 0, then release and let it run out.
        bus.keys = 16'h0020; expect_ev(4'b0001, 16'h0005, 4'b0001, 1'b0, 1'b0); tick(2);
        bus.keys = 16'h0000; expect_ev(4'b0000, 16'h0005, 4'b0000, 1'b0, 1'b0); tick(10);

        // Four simultaneous presses, one per edge.
        bus.keys = 16'h000F;
        expect_ev(4'b0001, 16'h0000, 4'b0001, 1'b0, 1'b1);
        expect_ev(4'b0011, 16'h0010, 4'b0010, 1'b0, 1'b1);
        expect_ev(4'b0111, 16'h0210, 4'b0100, 1'b0, 1'b1);
        expect_ev(4'b1111, 16'h3210, 4'b1000, 1'b0, 1'b0);
        tick(6);

        // Steal oldest HELD; releasing the stolen key does nothing.
        bus.keys = 16'h020F; expect_ev(4'b1111, 16'h3219, 4'b0001, 1'b1, 1'b0); tick(2);
        bus.keys = 16'h020E; tick(3);

        // RELEASING beats HELD as a steal target.
        bus.release_len = 16'd100;
        bus.keys = 16'h020A; expect_ev(4'b1011, 16'h3219, 4'b0000, 1'b0, 1'b0); tick(2);
        bus.keys = 16'h028A; expect_ev(4'b1111, 16'h3719, 4'b0100, 1'b1, 1'b0); tick(2);

        // Two releases, then re-press key 3: its own voice, not the older RELEASING one.
        bus.keys = 16'h0280;
        expect_ev(4'b1101, 16'h3719, 4'b0000, 1'b0, 1'b1);
        expect_ev(4'b0101, 16'h3719, 4'b0000, 1'b0, 1'b0);
        tick(3);
        bus.keys = 16'h0288; expect_ev(4'b1101, 16'h3719, 4'b1000, 1'b0, 1'b0); tick(2);
        bus.keys = 16'h0298; expect_ev(4'b1111, 16'h3749, 4'b0010, 1'b1, 1'b0); tick(2);

        // Release 4 beats press 8 on the same edge; key 12 pulse gets cancelled.
        bus.keys = 16'h0388; expect_ev(4'b1101, 16'h3749, 4'b0000, 1'b0, 1'b1); tick(1);
        bus.keys = 16'h1388; expect_ev(4'b1111, 16'h3789, 4'b0010, 1'b1, 1'b1); tick(1);
        bus.keys = 16'h0388; expect_ev(4'b1111, 16'h3789, 4'b0000, 1'b0, 1'b0); tick(3);

        // Enable low with three voices HELD; key pressed while disabled stays silent.
        bus.keys = 16'h0380; expect_ev(4'b0111, 16'h3789, 4'b0000, 1'b0, 1'b0); tick(2);
        bus.enable = 1'b0;   expect_ev(4'b0000, 16'h3789, 4'b0000, 1'b0, 1'b0); tick(2);
        bus.keys = 16'h03A0; tick(2);
        bus.enable = 1'b1;   tick(4);
        bus.keys = 16'h03A1; expect_ev(4'b0001, 16'h3780, 4'b0001, 1'b0, 1'b0); tick(2);

        // release_len = 0 frees the voice one edge after it starts releasing.
        bus.release_len = 16'd0;
        bus.keys = 16'h03A0; expect_ev(4'b0000, 16'h3780, 4'b0000, 1'b0, 1'b0); tick(2);
        bus.keys = 16'h03A2; expect_ev(4'b0001, 16'h3781, 4'b0001, 1'b0, 1'b0); tick(2);

        // Asynchronous reset between edges, then held keys replay as presses.
        #2;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        check_now("async_reset", '0);
        @(posedge clk);
        #1;
        expect_ev(4'b0001, 16'h0001, 4'b0001, 1'b0, 1'b1);
        expect_ev(4'b0011, 16'h0051, 4'b0010, 1'b0, 1'b1);
        expect_ev(4'b0111, 16'h0751, 4'b0100, 1'b0, 1'b1);
        expect_ev(4'b1111, 16'h8751, 4'b1000, 1'b0, 1'b1);
        expect_ev(4'b1111, 16'h8759, 4'b0001, 1'b1, 1'b0);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        tick(8);

        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL missing_events got=%0d required=0 outstanding", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
